// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings for the main-RAM port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_F    = 2'd1,
    OWN_D    = 2'd2,
    OWN_X    = 2'd3
  } owner_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam int DEFAULT_ADDR_W       = 8;
  localparam int DEFAULT_STARVE_LIMIT = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester, loader-control and RAM bus bundle
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8
);

  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [31:0]       f_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;

  logic              x_req;
  logic              x_we;
  logic [ADDR_W-1:0] x_addr;
  logic [31:0]       x_wdata;
  logic              x_gnt;
  logic              x_rvalid;
  logic [31:0]       x_rdata;
  logic              x_halt;

  logic              cpu_stall;
  logic              halted;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // Arbiter side
  modport slave (
    input  f_req, f_addr,
    output f_gnt, f_rvalid, f_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    input  x_req, x_we, x_addr, x_wdata, x_halt,
    output x_gnt, x_rvalid, x_rdata,
    output cpu_stall, halted,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requester and RAM side
  modport master (
    output f_req, f_addr,
    input  f_gnt, f_rvalid, f_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    output x_req, x_we, x_addr, x_wdata, x_halt,
    input  x_gnt, x_rvalid, x_rdata,
    input  cpu_stall, halted,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_arb_prio3.sv
// rtl/mem_port_arbiter_arb_prio3.sv - 3-way priority picker, X > D > F unless F is promoted
module arb_prio3
  import mem_port_arbiter_pkg::*;
(
  input  logic   reqF,
  input  logic   reqD,
  input  logic   reqX,
  input  logic   promoteF,
  output owner_t winner
);

  always_comb begin
    winner = OWN_NONE;
    if (promoteF && reqF) begin
      winner = OWN_F;
    end else if (reqX) begin
      winner = OWN_X;
    end else if (reqD) begin
      winner = OWN_D;
    end else if (reqF) begin
      winner = OWN_F;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares main RAM between fetch, load/store and the loader,
// with a halt mode that hands the loader exclusive ownership
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEFAULT_ADDR_W,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            state, stateNext;
  owner_t            rspOwner, rspOwnerNext;
  owner_t            winner;
  logic [3:0]        starveCnt, starveCntNext;
  logic              cpuAllowed;
  logic              promoteF;
  logic              fGnt, dGnt, xGnt;
  logic              memEn, memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [31:0]       memWdata;
  logic              cpuStall;

  assign cpuAllowed = (state == ST_RUN);
  assign promoteF   = cpuAllowed && (starveCnt == LIMIT);

  arb_prio3 uPrio (
    .reqF     (bus.f_req && cpuAllowed),
    .reqD     (bus.d_req && cpuAllowed),
    .reqX     (bus.x_req),
    .promoteF (promoteF),
    .winner   (winner)
  );

  always_comb begin
    fGnt     = (winner == OWN_F);
    dGnt     = (winner == OWN_D);
    xGnt     = (winner == OWN_X);
    memEn    = 1'b0;
    memWe    = 1'b0;
    memAddr  = '0;
    memWdata = '0;
    case (winner)
      OWN_F: begin
        memEn   = 1'b1;
        memAddr = bus.f_addr;
      end
      OWN_D: begin
        memEn    = 1'b1;
        memWe    = bus.d_we;
        memAddr  = bus.d_addr;
        memWdata = bus.d_wdata;
      end
      OWN_X: begin
        memEn    = 1'b1;
        memWe    = bus.x_we;
        memAddr  = bus.x_addr;
        memWdata = bus.x_wdata;
      end
      default: ;
    endcase
    // Only reads leave a response in flight
    rspOwnerNext = (memEn && !memWe) ? winner : OWN_NONE;
  end

  always_comb begin
    starveCntNext = starveCnt;
    if (!bus.f_req || fGnt) begin
      starveCntNext = '0;
    end else if (cpuAllowed && starveCnt < LIMIT) begin
      starveCntNext = starveCnt + 4'd1;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_RUN: begin
        if (bus.x_halt) stateNext = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!bus.x_halt) begin
          stateNext = ST_RUN;
        end else if (rspOwnerNext != OWN_F && rspOwnerNext != OWN_D) begin
          stateNext = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (!bus.x_halt) stateNext = ST_RUN;
      end
      default: stateNext = ST_RUN;
    endcase
  end

  always_comb begin
    cpuStall = !cpuAllowed
               || (bus.f_req && !fGnt)
               || (bus.d_req && !dGnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      rspOwner  <= OWN_NONE;
      starveCnt <= '0;
    end else begin
      state     <= stateNext;
      rspOwner  <= rspOwnerNext;
      starveCnt <= starveCntNext;
    end
  end

  assign bus.f_gnt     = fGnt;
  assign bus.d_gnt     = dGnt;
  assign bus.x_gnt     = xGnt;
  assign bus.mem_en    = memEn;
  assign bus.mem_we    = memWe;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign bus.cpu_stall = cpuStall;
  assign bus.halted    = (state == ST_HALTED);

  // Read data is steered only to its owner; others see zero
  assign bus.f_rvalid = (rspOwner == OWN_F);
  assign bus.d_rvalid = (rspOwner == OWN_D);
  assign bus.x_rvalid = (rspOwner == OWN_X);
  assign bus.f_rdata  = (rspOwner == OWN_F) ? bus.mem_rdata : 32'd0;
  assign bus.d_rdata  = (rspOwner == OWN_D) ? bus.mem_rdata : 32'd0;
  assign bus.x_rdata  = (rspOwner == OWN_X) ? bus.mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nChecks = 0;
  int   nFails  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(8)) bus ();

  mem_port_arbiter #(.ADDR_W(8), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       fReq;
    logic       dReq;
    logic       dWe;
    logic       xReq;
    logic       xWe;
    logic [2:0] expGnt;   // {f, d, x}
    logic       expWe;
    logic       expStall;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clearReqs();
    bus.f_req  = 1'b0;
    bus.d_req  = 1'b0;
    bus.d_we   = 1'b0;
    bus.x_req  = 1'b0;
    bus.x_we   = 1'b0;
  endtask

  function automatic logic [2:0] gntVec();
    return {bus.f_gnt, bus.d_gnt, bus.x_gnt};
  endfunction

  function automatic logic [2:0] rvalidVec();
    return {bus.f_rvalid, bus.d_rvalid, bus.x_rvalid};
  endfunction

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b001, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b001, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 1'b0, 1'b1};

    clearReqs();
    bus.x_halt    = 1'b0;
    bus.f_addr    = 8'h00;
    bus.d_addr    = 8'h00;
    bus.x_addr    = 8'h00;
    bus.d_wdata   = 32'd0;
    bus.x_wdata   = 32'd0;
    bus.mem_rdata = 32'h1111_1111;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("reset_gnt",    {29'd0, gntVec()}, 32'd0);
    check("reset_rvalid", {29'd0, rvalidVec()}, 32'd0);
    check("reset_rdata",  bus.f_rdata | bus.d_rdata | bus.x_rdata, 32'd0);
    check("reset_mem",    {30'd0, bus.mem_en, bus.mem_we}, 32'd0);
    check("reset_status", {30'd0, bus.cpu_stall, bus.halted}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single fetch read and its response
    @(negedge clk);
    bus.f_req  = 1'b1;
    bus.f_addr = 8'h10;
    #2;
    check("t1_f_gnt",    {31'd0, bus.f_gnt}, 32'd1);
    check("t1_mem_addr", {24'd0, bus.mem_addr}, 32'h10);
    check("t1_mem_rd",   {30'd0, bus.mem_en, bus.mem_we}, 32'b10);
    @(negedge clk);
    bus.f_req     = 1'b0;
    bus.mem_rdata = 32'hDEAD_BEEF;
    #2;
    check("t1_f_rvalid", {31'd0, bus.f_rvalid}, 32'd1);
    check("t1_f_rdata",  bus.f_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    #2;
    check("t1_rvalid_once", {29'd0, rvalidVec()}, 32'd0);

    // Single-cycle combinational grant table, idle cycle between vectors
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.f_req  = vecs[i].fReq;
      bus.d_req  = vecs[i].dReq;
      bus.d_we   = vecs[i].dWe;
      bus.x_req  = vecs[i].xReq;
      bus.x_we   = vecs[i].xWe;
      bus.f_addr = 8'h11;
      bus.d_addr = 8'h22;
      bus.x_addr = 8'h33;
      #2;
      check($sformatf("vec%0d_gnt", i), {29'd0, gntVec()}, {29'd0, vecs[i].expGnt});
      check($sformatf("vec%0d_en", i), {31'd0, bus.mem_en}, {31'd0, |vecs[i].expGnt});
      check($sformatf("vec%0d_we", i), {31'd0, bus.mem_we}, {31'd0, vecs[i].expWe});
      check($sformatf("vec%0d_stall", i), {31'd0, bus.cpu_stall}, {31'd0, vecs[i].expStall});
      @(negedge clk);
      clearReqs();
    end

    // Starvation promotion: X wins four times, then F, then X again
    begin
      logic [2:0] prevExp;
      prevExp = 3'b000;
      for (int c = 0; c < 6; c++) begin
        logic [2:0] expGnt;
        @(negedge clk);
        if (c == 0) begin
          bus.f_req  = 1'b1;
          bus.f_addr = 8'h40;
          bus.d_req  = 1'b1;
          bus.d_we   = 1'b0;
          bus.d_addr = 8'h20;
          bus.x_req  = 1'b1;
          bus.x_we   = 1'b0;
          bus.x_addr = 8'h30;
        end
        bus.mem_rdata = 32'hA000_0000 + 32'(c);
        #2;
        expGnt = (c == 4) ? 3'b100 : 3'b001;
        check($sformatf("t2_c%0d_gnt", c), {29'd0, gntVec()}, {29'd0, expGnt});
        check($sformatf("t2_c%0d_addr", c), {24'd0, bus.mem_addr}, (c == 4) ? 32'h40 : 32'h30);
        if (c > 0) begin
          check($sformatf("t2_c%0d_rvalid", c), {29'd0, rvalidVec()}, {29'd0, prevExp});
          check($sformatf("t2_c%0d_rdata", c),
                prevExp[2] ? bus.f_rdata : bus.x_rdata, 32'hA000_0000 + 32'(c));
        end
        prevExp = expGnt;
      end
      @(negedge clk);
      clearReqs();
      @(negedge clk);
    end

    // Store with concurrent fetch
    @(negedge clk);
    bus.f_req   = 1'b1;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 8'h05;
    bus.d_wdata = 32'h1234_5678;
    #2;
    check("t3_gnt",       {29'd0, gntVec()}, 32'b010);
    check("t3_mem_we",    {31'd0, bus.mem_we}, 32'd1);
    check("t3_mem_addr",  {24'd0, bus.mem_addr}, 32'h05);
    check("t3_mem_wdata", bus.mem_wdata, 32'h1234_5678);
    check("t3_stall",     {31'd0, bus.cpu_stall}, 32'd1);
    @(negedge clk);
    clearReqs();
    #2;
    check("t3_no_rvalid", {29'd0, rvalidVec()}, 32'd0);
    @(negedge clk);

    // Load during halt request, drain, halted
    @(negedge clk);
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 8'h20;
    bus.x_halt = 1'b1;
    #2;
    check("t4_d_gnt",  {29'd0, gntVec()}, 32'b010);
    check("t4_halted0", {31'd0, bus.halted}, 32'd0);
    @(negedge clk);
    bus.d_req     = 1'b0;
    bus.f_req     = 1'b1;
    bus.f_addr    = 8'h44;
    bus.mem_rdata = 32'h0BAD_F00D;
    #2;
    check("t4_d_rvalid", {29'd0, rvalidVec()}, 32'b010);
    check("t4_d_rdata",  bus.d_rdata, 32'h0BAD_F00D);
    check("t4_drain",    {29'd0, bus.f_gnt, bus.cpu_stall, bus.halted}, 32'b010);
    @(negedge clk);
    #2;
    check("t4_halted",   {29'd0, bus.f_gnt, bus.cpu_stall, bus.halted}, 32'b011);
    check("t4_mem_idle", {31'd0, bus.mem_en}, 32'd0);

    // Loader writes back-to-back while halted, CPU still requesting
    bus.d_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.x_req   = 1'b1;
      bus.x_we    = 1'b1;
      bus.x_addr  = 8'(i);
      bus.x_wdata = 32'hC0DE_0000 + 32'(i);
      #2;
      check($sformatf("t5_w%0d_gnt", i), {29'd0, gntVec()}, 32'b001);
      check($sformatf("t5_w%0d_we", i), {30'd0, bus.mem_en, bus.mem_we}, 32'b11);
      check($sformatf("t5_w%0d_addr", i), {24'd0, bus.mem_addr}, 32'(i));
      check($sformatf("t5_w%0d_wdata", i), bus.mem_wdata, 32'hC0DE_0000 + 32'(i));
      check($sformatf("t5_w%0d_halted", i), {31'd0, bus.halted}, 32'd1);
    end
    @(negedge clk);
    bus.x_req  = 1'b0;
    bus.x_we   = 1'b0;
    bus.d_req  = 1'b0;
    bus.x_halt = 1'b0;
    #2;
    check("t4_release_cycle", {29'd0, bus.f_gnt, bus.cpu_stall, bus.halted}, 32'b011);
    @(negedge clk);
    #2;
    check("t4_run_f_gnt", {29'd0, bus.f_gnt, bus.cpu_stall, bus.halted}, 32'b100);
    check("t4_run_addr",  {24'd0, bus.mem_addr}, 32'h44);

    // Asynchronous reset with a fetch response pending
    @(negedge clk);
    bus.f_req     = 1'b0;
    bus.mem_rdata = 32'h55AA_55AA;
    #1;
    check("t6_pre_rvalid", {31'd0, bus.f_rvalid}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("t6_rvalid",  {29'd0, rvalidVec()}, 32'd0);
    check("t6_rdata",   bus.f_rdata | bus.d_rdata | bus.x_rdata, 32'd0);
    check("t6_outputs", {27'd0, bus.mem_en, bus.mem_we, bus.cpu_stall, bus.halted, |gntVec()}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("t6_after_rvalid", {29'd0, rvalidVec()}, 32'd0);
    @(negedge clk);
    bus.f_req  = 1'b1;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    #2;
    check("t6_run_gnt", {29'd0, gntVec()}, 32'b010);
    @(negedge clk);
    clearReqs();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
